// File: rtl/msg_link_pkg.sv
// Shared types and constants for the msg_link serial transmitter.
// Parity framing is enabled by defining MSG_LINK_PARITY_EN.
package msg_link_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_ACK_TIMEOUT = 16;
  localparam int DEF_MAX_RETRY   = 2;

  localparam logic START_BIT = 1'b1;
  localparam logic IDLE_LINE = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    WAIT_ACK = 3'd4
  } msg_link_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msg_ack_timer.sv
// Acknowledge timer: counts enabled cycles from zero and saturates at ACK_TIMEOUT.
// expired is high while the count equals ACK_TIMEOUT.
module msg_ack_timer
  import msg_link_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(ACK_TIMEOUT);

  logic [TW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/msg_link_tx.sv
// Serial message transmitter: start bit, LSB-first data, optional even parity
// (MSG_LINK_PARITY_EN), then waits for ack with timed retransmission.
module msg_link_tx
  import msg_link_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] msg_in,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic             line_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output msg_link_state_e  dbg_state
);

  localparam int IDX_W = width_min1(WIDTH);
  localparam int RC_W  = width_min1(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [RC_W-1:0]  RETRY_LIM = RC_W'(MAX_RETRY);

  // Handshake: a word transfers on any rising edge where msg_valid and
  // msg_ready are both high; msg_ready is high only in IDLE and does not
  // depend on msg_valid.

  msg_link_state_e  state;
  logic [WIDTH-1:0] latched;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] idx_next;
  logic [RC_W-1:0]  retry_cnt;
  logic             last_bit;
  logic             timer_clear;
  logic             timer_en;
  logic             expired;

  assign idx_next    = bit_idx + IDX_W'(1);
  assign last_bit    = (bit_idx == LAST_IDX);
  // Held clear outside WAIT_ACK so every entry starts counting from zero.
  assign timer_clear = (state != WAIT_ACK);
  assign timer_en    = (state == WAIT_ACK);

  msg_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  // line_out, done and fail are registered alongside the state so the
  // line value always matches the state occupying that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      latched   <= '0;
      bit_idx   <= '0;
      retry_cnt <= '0;
      line_out  <= IDLE_LINE;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        IDLE: begin
          line_out <= IDLE_LINE;
          if (msg_valid) begin
            latched   <= msg_in;
            retry_cnt <= '0;
            state     <= START;
            line_out  <= START_BIT;
          end
        end
        START: begin
          bit_idx  <= '0;
          line_out <= latched[0];
          state    <= DATA;
        end
        DATA: begin
          if (last_bit) begin
`ifdef MSG_LINK_PARITY_EN
            line_out <= ^latched;
            state    <= PARITY;
`else
            line_out <= IDLE_LINE;
            state    <= WAIT_ACK;
`endif
          end else begin
            bit_idx  <= idx_next;
            line_out <= latched[idx_next];
          end
        end
`ifdef MSG_LINK_PARITY_EN
        PARITY: begin
          line_out <= IDLE_LINE;
          state    <= WAIT_ACK;
        end
`endif
        WAIT_ACK: begin
          line_out <= IDLE_LINE;
          // An ack on the expiry edge still counts as success.
          if (ack_in) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (expired) begin
            if (retry_cnt < RETRY_LIM) begin
              retry_cnt <= retry_cnt + RC_W'(1);
              line_out  <= START_BIT;
              state     <= START;
            end else begin
              fail  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          line_out <= IDLE_LINE;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign msg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
